// File: rtl/sevenseg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : sevenseg_scan_driver
// Description : Multiplexed hex seven-segment scanner with frame-synchronous
//               double-buffered update, leading-zero blanking and polarity.
// Revision    : 1.0 - initial release
// ============================================================================
module sevenseg_scan_driver #(
    parameter int N_DIGITS    = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic [N_DIGITS-1:0]     digit_en,
    input  logic                    lz_blank,
    input  logic                    load,
    output logic [6:0]              segments,
    output logic                    dp,
    output logic [N_DIGITS-1:0]     anodes,
    output logic                    frame_done
);

    localparam int c_presc_w = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_idx_w   = $clog2(N_DIGITS);
    localparam logic [c_presc_w-1:0] c_presc_max = c_presc_w'(REFRESH_DIV - 1);
    localparam logic [c_idx_w-1:0]   c_idx_max   = c_idx_w'(N_DIGITS - 1);
    localparam logic                 c_inv       = (ACTIVE_LOW != 0);

    logic [c_presc_w-1:0]  r_presc;
    logic [c_idx_w-1:0]    r_idx;
    // Enables are held inverted (blank mask) so a cleared display shows zeros.
    logic [4*N_DIGITS-1:0] r_disp_val,   r_pend_val;
    logic [N_DIGITS-1:0]   r_disp_dp,    r_pend_dp;
    logic [N_DIGITS-1:0]   r_disp_blank, r_pend_blank;
    logic                  r_pend_flag;
    logic [6:0]            r_segments;
    logic                  r_dp;
    logic [N_DIGITS-1:0]   r_anodes;

    logic                  w_tick;
    logic                  w_wrap;
    logic [4*N_DIGITS-1:0] w_shifted;
    logic [3:0]            w_nibble;
    logic                  w_blank;
    logic [6:0]            w_seg_raw;
    logic [6:0]            w_seg;
    logic                  w_dp;
    logic [N_DIGITS-1:0]   w_anode;

    assign w_tick    = (r_presc == c_presc_max);
    assign w_wrap    = w_tick && (r_idx == c_idx_max);
    assign w_shifted = r_disp_val >> {r_idx, 2'b00};
    assign w_nibble  = w_shifted[3:0];
    // Everything from the current nibble upward is zero -> leading zero.
    assign w_blank   = r_disp_blank[r_idx] ||
                       (lz_blank && (r_idx != '0) && (w_shifted == '0));
    assign w_anode   = {{(N_DIGITS-1){1'b0}}, 1'b1} << r_idx;

    always_comb begin
        w_seg_raw = 7'b0000000;
        case (w_nibble)
            4'h0: w_seg_raw = 7'b1111110;
            4'h1: w_seg_raw = 7'b0110000;
            4'h2: w_seg_raw = 7'b1101101;
            4'h3: w_seg_raw = 7'b1111001;
            4'h4: w_seg_raw = 7'b0110011;
            4'h5: w_seg_raw = 7'b1011011;
            4'h6: w_seg_raw = 7'b1011111;
            4'h7: w_seg_raw = 7'b1110000;
            4'h8: w_seg_raw = 7'b1111111;
            4'h9: w_seg_raw = 7'b1111011;
            4'hA: w_seg_raw = 7'b1110111;
            4'hB: w_seg_raw = 7'b0011111;
            4'hC: w_seg_raw = 7'b1001110;
            4'hD: w_seg_raw = 7'b0111101;
            4'hE: w_seg_raw = 7'b1001111;
            4'hF: w_seg_raw = 7'b1000111;
            default: w_seg_raw = 7'b0000000;
        endcase
        w_seg = w_blank ? 7'b0000000 : w_seg_raw;
        w_dp  = !w_blank && r_disp_dp[r_idx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc      <= '0;
            r_idx        <= '0;
            r_disp_val   <= '0;
            r_disp_dp    <= '0;
            r_disp_blank <= '0;
            r_pend_val   <= '0;
            r_pend_dp    <= '0;
            r_pend_blank <= '0;
            r_pend_flag  <= 1'b0;
            r_segments   <= {7{c_inv}};
            r_dp         <= c_inv;
            r_anodes     <= {N_DIGITS{c_inv}};
        end else begin
            r_presc <= w_tick ? '0 : r_presc + c_presc_w'(1);
            if (w_tick) begin
                r_idx <= (r_idx == c_idx_max) ? '0 : r_idx + c_idx_w'(1);
            end

            // A load on the boundary cycle bypasses the pending buffer.
            if (w_wrap && load) begin
                r_disp_val   <= value;
                r_disp_dp    <= dp_in;
                r_disp_blank <= ~digit_en;
                r_pend_flag  <= 1'b0;
            end else if (w_wrap && r_pend_flag) begin
                r_disp_val   <= r_pend_val;
                r_disp_dp    <= r_pend_dp;
                r_disp_blank <= r_pend_blank;
                r_pend_flag  <= 1'b0;
            end else if (load) begin
                r_pend_val   <= value;
                r_pend_dp    <= dp_in;
                r_pend_blank <= ~digit_en;
                r_pend_flag  <= 1'b1;
            end

            r_segments <= w_seg ^ {7{c_inv}};
            r_dp       <= w_dp ^ c_inv;
            r_anodes   <= w_anode ^ {N_DIGITS{c_inv}};
        end
    end

    assign segments   = r_segments;
    assign dp         = r_dp;
    assign anodes     = r_anodes;
    assign frame_done = w_wrap;

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_sevenseg_scan_driver
// Description : Directed bench for sevenseg_scan_driver, high- and low-true.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sevenseg_scan_driver;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  digit_en = '0;
    logic        lz_blank = 1'b0;
    logic        load = 1'b0;

    logic [6:0]  seg_h, seg_l;
    logic        dp_h, dp_l;
    logic [3:0]  an_h, an_l;
    logic        fd_h, fd_l;

    int checks = 0;
    int errors = 0;

    sevenseg_scan_driver #(.N_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(0)) dut (
        .clk(clk), .reset(reset), .value(value), .dp_in(dp_in),
        .digit_en(digit_en), .lz_blank(lz_blank), .load(load),
        .segments(seg_h), .dp(dp_h), .anodes(an_h), .frame_done(fd_h)
    );

    sevenseg_scan_driver #(.N_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1)) dut_al (
        .clk(clk), .reset(reset), .value(value), .dp_in(dp_in),
        .digit_en(digit_en), .lz_blank(lz_blank), .load(load),
        .segments(seg_l), .dp(dp_l), .anodes(an_l), .frame_done(fd_l)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] val;
        logic [3:0]  dpi;
        logic [3:0]  en;
        logic        lz;
        logic [27:0] seg;   // {digit3, digit2, digit1, digit0}
        logic [3:0]  dpx;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_inactive(input string tag);
        chk({tag, " an"},   {28'd0, an_h}, 32'h0);
        chk({tag, " seg"},  {25'd0, seg_h}, 32'h0);
        chk({tag, " dp"},   {31'd0, dp_h}, 32'h0);
        chk({tag, " fd"},   {31'd0, fd_h}, 32'h0);
        chk({tag, " anL"},  {28'd0, an_l}, 32'hF);
        chk({tag, " segL"}, {25'd0, seg_l}, 32'h7F);
        chk({tag, " dpL"},  {31'd0, dp_l}, 32'h1);
    endtask

    task automatic wait_fd();
        bit found = 1'b0;
        for (int n = 0; n < 64 && !found; n++) begin
            @(negedge clk);
            found = fd_h;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL frame_done timeout: got 0 expected 1");
        end
    endtask

    // Entered at a negedge 'pre' cycles before the middle of digit 0's dwell.
    task automatic check_frame(input int pre, input logic [27:0] seg,
                               input logic [3:0] dpx, input string tag);
        logic [3:0] an;
        logic [6:0] s;
        repeat (pre) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) repeat (4) @(negedge clk);
            an = 4'(1 << k);
            s  = seg[7*k +: 7];
            chk($sformatf("%s d%0d an", tag, k),   {28'd0, an_h}, {28'd0, an});
            chk($sformatf("%s d%0d seg", tag, k),  {25'd0, seg_h}, {25'd0, s});
            chk($sformatf("%s d%0d dp", tag, k),   {31'd0, dp_h}, {31'd0, dpx[k]});
            an = ~an;
            s  = ~s;
            chk($sformatf("%s d%0d anL", tag, k),  {28'd0, an_l}, {28'd0, an});
            chk($sformatf("%s d%0d segL", tag, k), {25'd0, seg_l}, {25'd0, s});
            chk($sformatf("%s d%0d dpL", tag, k),  {31'd0, dp_l}, {31'd0, ~dpx[k]});
        end
    endtask

    // Called at the negedge right after the last reset edge, reset now low.
    task automatic post_reset(input string tag);
        chk_inactive({tag, " first cycle"});
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk($sformatf("%s dwell%0d an", tag, j),  {28'd0, an_h}, 32'h1);
            chk($sformatf("%s dwell%0d seg", tag, j), {25'd0, seg_h}, 32'h7E);
        end
        @(negedge clk);
        chk({tag, " next digit an"}, {28'd0, an_h}, 32'h2);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
        value = v; dp_in = d; digit_en = e; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        vecs[0] = '{16'h1234, 4'b0000, 4'hF, 1'b0,
                    {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011}, 4'b0000};
        vecs[1] = '{16'hABCD, 4'b0000, 4'hF, 1'b0,
                    {7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101}, 4'b0000};
        vecs[2] = '{16'h0050, 4'b0000, 4'hF, 1'b1,
                    {7'b0000000, 7'b0000000, 7'b1011011, 7'b1111110}, 4'b0000};
        vecs[3] = '{16'h0000, 4'b0000, 4'hF, 1'b1,
                    {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110}, 4'b0000};
        vecs[4] = '{16'h1234, 4'b0100, 4'b1110, 1'b0,
                    {7'b0110000, 7'b1101101, 7'b1111001, 7'b0000000}, 4'b0100};
        vecs[5] = '{16'h7E9F, 4'b1001, 4'hF, 1'b1,
                    {7'b1110000, 7'b1001111, 7'b1111011, 7'b1000111}, 4'b1001};
        vecs[6] = '{16'h0608, 4'b1111, 4'hF, 1'b1,
                    {7'b0000000, 7'b1011111, 7'b1111110, 7'b1111111}, 4'b0111};
        vecs[7] = '{16'h0000, 4'b0000, 4'b1010, 1'b0,
                    {7'b1111110, 7'b0000000, 7'b1111110, 7'b0000000}, 4'b0000};

        // Power-on reset
        repeat (3) @(negedge clk);
        chk_inactive("reset");
        reset = 1'b0;
        post_reset("por");

        // Frame period and pulse width
        wait_fd();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fd_h && n < 40);
        chk("frame period", n, 16);

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            lz_blank = vecs[i].lz;
            do_load(vecs[i].val, vecs[i].dpi, vecs[i].en);
            wait_fd();
            check_frame(3, vecs[i].seg, vecs[i].dpx, $sformatf("vec%0d", i));
        end

        // Mid-frame load: current frame keeps old data
        lz_blank = 1'b0;
        wait_fd();
        @(negedge clk);
        do_load(16'hABCD, 4'h0, 4'hF);
        check_frame(1, vecs[7].seg, vecs[7].dpx, "midload old");
        wait_fd();
        check_frame(3, vecs[1].seg, 4'h0, "midload new");

        // Only the last load before the boundary is shown
        wait_fd();
        @(negedge clk);
        do_load(16'h5555, 4'hF, 4'hF);
        @(negedge clk);
        do_load(16'h6666, 4'h0, 4'hF);
        wait_fd();
        check_frame(3, {4{7'b1011111}}, 4'h0, "overwrite");

        // Load exactly on the wrap cycle
        wait_fd();
        do_load(16'h8888, 4'h0, 4'hF);
        chk("coincident pend flag", {31'd0, dut.r_pend_flag}, 32'h0);
        check_frame(2, {4{7'b1111111}}, 4'h0, "coincident");

        // Reset mid-scan discards pending data
        wait_fd();
        repeat (2) @(negedge clk);
        do_load(16'h1357, 4'hF, 4'hF);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        post_reset("midreset");
        wait_fd();
        check_frame(3, {4{7'b1111110}}, 4'h0, "after reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
